// File: rtl/operand_access_unit.sv
// rtl/operand_access_unit.sv - operand read / result write-back FSM over a single-port req/ack memory bus
// Optional feature macro: OAU_TIMEOUT_EN (bus-request timeout with sticky error flag)
module operand_access_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] source_addr,
  input  logic [DATA_WIDTH-1:0] dest_addr,
  input  logic                  source_mem,
  input  logic                  dest_mem,
  input  logic                  dest_read,
  input  logic                  write_result,
  input  logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] source_data,
  output logic [DATA_WIDTH-1:0] dest_data,
  output logic [DATA_WIDTH-1:0] destination_write,
  output logic                  store_value,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_SRC = 3'd1,
    RD_DST = 3'd2,
    EXEC   = 3'd3,
    WR_DST = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] dst_addr_q;
  logic                  dst_mem_q;
  logic                  dst_read_q;
  logic                  write_q;
  logic                  timeout_hit;

`ifdef OAU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // The outstanding request is abandoned on the last allowed unacknowledged cycle.
  assign timeout_hit = mem_req && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count unacknowledged request cycles; the count restarts whenever the request line is idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      error    <= 1'b0;
    end else begin
      if (!mem_req)
        wait_cnt <= '0;
      else if (!mem_ack)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit)
        error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // Operation sequencer: all outputs are registered and updated alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      dst_addr_q        <= '0;
      dst_mem_q         <= 1'b0;
      dst_read_q        <= 1'b0;
      write_q           <= 1'b0;
      source_data       <= '0;
      dest_data         <= '0;
      destination_write <= '0;
      store_value       <= 1'b0;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done        <= 1'b0;
      store_value <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            dst_addr_q <= dest_addr;
            dst_mem_q  <= dest_mem;
            dst_read_q <= dest_read;
            write_q    <= write_result;
            if (!source_mem)
              source_data <= source_addr;
            if (!(dest_mem && dest_read))
              dest_data <= dest_addr;
            if (source_mem) begin
              state    <= RD_SRC;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= source_addr;
            end else if (dest_mem && dest_read) begin
              state    <= RD_DST;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= dest_addr;
            end else begin
              state <= EXEC;
            end
          end
        end

        // A destination read that follows a source read enters with mem_req low, giving
        // the bus its mandatory idle request cycle before the next request is raised.
        RD_SRC, RD_DST: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (state == RD_SRC) begin
              source_data <= mem_rdata;
              if (dst_mem_q && dst_read_q) begin
                state    <= RD_DST;
                mem_addr <= dst_addr_q;
              end else begin
                state <= EXEC;
              end
            end else begin
              dest_data <= mem_rdata;
              state     <= EXEC;
            end
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        EXEC: begin
          if (write_q && dst_mem_q) begin
            state     <= WR_DST;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= dst_addr_q;
            mem_wdata <= result;
          end else begin
            if (write_q) begin
              destination_write <= result;
              store_value       <= 1'b1;
            end
            done  <= 1'b1;
            state <= DONE;
          end
        end

        WR_DST: begin
          if (mem_ack || timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_access_unit.sv
// tb/tb_operand_access_unit.sv - randomized self-checking bench for operand_access_unit
module tb_operand_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] source_addr = '0, dest_addr = '0;
  logic        source_mem = 1'b0, dest_mem = 1'b0, dest_read = 1'b0, write_result = 1'b0;
  logic [15:0] result;
  logic [15:0] source_data, dest_data, destination_write;
  logic        store_value, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        busy, done, error;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic [15:0] bus_mem [0:255];
  logic [15:0] ref_mem [0:255];
  txn_t        act_q[$];
  int          wait_q[$];
  bit          resp_en = 1'b1;
  int          done_cnt = 0, store_cnt = 0, req_cnt = 0;

  // ALU stand-in: combinational sum of the latched operands
  assign result = source_data + dest_data;

  operand_access_unit #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(15)) dut (
    .clock(clock), .reset(reset), .start(start),
    .source_addr(source_addr), .dest_addr(dest_addr),
    .source_mem(source_mem), .dest_mem(dest_mem), .dest_read(dest_read),
    .write_result(write_result), .result(result),
    .source_data(source_data), .dest_data(dest_data),
    .destination_write(destination_write), .store_value(store_value),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Memory responder: per request, waits the next queued number of cycles, then acks once
  initial begin
    int  cur_wait;
    bit  in_req;
    cur_wait = 0;
    in_req   = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
      if (!mem_req || reset) begin
        in_req = 1'b0;
      end else if (resp_en) begin
        if (!in_req) begin
          in_req   = 1'b1;
          cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        end
        if (cur_wait == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            bus_mem[mem_addr[7:0]] = mem_wdata;
            act_q.push_back({1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = bus_mem[mem_addr[7:0]];
            act_q.push_back({1'b0, mem_addr, mem_rdata});
          end
        end else begin
          cur_wait--;
        end
      end
    end
  end

  // Bus protocol and pulse monitor, sampled mid-cycle
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clock) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (store_value) begin
        store_cnt++;
        checks++;
        if (!done) begin failures++; $display("FAIL store_with_done: store_value=1 done=%0b required done=1", done); end
      end
      if (mem_req) req_cnt++;
      if (prev_ack) begin
        checks++;
        if (mem_req) begin failures++; $display("FAIL req_drop_after_ack: mem_req=%0b required 0", mem_req); end
      end else if (prev_req && mem_req) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {prev_we, prev_addr, prev_wdata}) begin
          failures++;
          $display("FAIL req_stable: we/addr/wdata=%0b/%h/%h required %0b/%h/%h", mem_we, mem_addr, mem_wdata, prev_we, prev_addr, prev_wdata);
        end
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we;
      prev_addr = mem_addr; prev_wdata = mem_wdata;
    end else begin
      prev_req = 1'b0; prev_ack = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    wait_q.delete();
    act_q.delete();
  endtask

  task automatic scramble_inputs();
    source_addr  = 16'($urandom);
    dest_addr    = 16'($urandom);
    source_mem   = 1'($urandom);
    dest_mem     = 1'($urandom);
    dest_read    = 1'($urandom);
    write_result = 1'($urandom);
  endtask

  // One operation checked against a specification-level model of its effects and timing
  task automatic run_op(input string name, input bit sm, input bit dm, input bit dr, input bit wr,
                        input logic [15:0] sa, input logic [15:0] da, input int w0, input int w1,
                        input int w2, input bit hold_start);
    logic [15:0] src_v, dst_v, res;
    txn_t        exp_q[$];
    int          lat_exp, lat, req_exp, d0, s0, r0;
    bit          exp_store, seen;
    src_v     = sm ? ref_mem[sa[7:0]] : sa;
    dst_v     = (dm && dr) ? ref_mem[da[7:0]] : da;
    res       = src_v + dst_v;
    exp_store = wr && !dm;
    lat_exp   = 2;
    req_exp   = 0;
    if (sm) begin
      exp_q.push_back({1'b0, sa, ref_mem[sa[7:0]]});
      wait_q.push_back(w0); lat_exp += 1 + w0; req_exp += 1 + w0;
    end
    if (dm && dr) begin
      exp_q.push_back({1'b0, da, ref_mem[da[7:0]]});
      wait_q.push_back(w1); req_exp += 1 + w1;
      // a read right behind another read first spends one cycle with the request line idle
      lat_exp += (sm ? 2 : 1) + w1;
    end
    if (wr && dm) begin
      exp_q.push_back({1'b1, da, res});
      ref_mem[da[7:0]] = res;
      wait_q.push_back(w2); lat_exp += 1 + w2; req_exp += 1 + w2;
    end
    d0 = done_cnt; s0 = store_cnt; r0 = req_cnt;

    @(posedge clock); #1;
    source_addr = sa; dest_addr = da; source_mem = sm; dest_mem = dm;
    dest_read = dr; write_result = wr; start = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      @(posedge clock); #1;
      lat++;
      if (!hold_start) start = 1'b0;
      scramble_inputs();
      seen = done;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL %s done_timeout: no done within %0d cycles", name, lat);
    end else begin
      checks++;
      if (lat != lat_exp) begin failures++; $display("FAIL %s latency: got %0d required %0d", name, lat, lat_exp); end
      checks++;
      if (store_value !== exp_store) begin failures++; $display("FAIL %s store_value: got %0b required %0b", name, store_value, exp_store); end
      if (exp_store) begin
        checks++;
        if (destination_write !== res) begin failures++; $display("FAIL %s destination_write: got %h required %h", name, destination_write, res); end
      end
      checks++;
      if ({source_data, dest_data} !== {src_v, dst_v}) begin
        failures++; $display("FAIL %s operands: got %h/%h required %h/%h", name, source_data, dest_data, src_v, dst_v);
      end
    end
    // start may still be high through the DONE cycle; it must be ignored there
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_after: got %0b required 0", name, busy); end
    checks++;
    if (done_cnt - d0 != 1 || store_cnt - s0 != int'(exp_store)) begin
      failures++; $display("FAIL %s pulse_count: done=%0d store=%0d required 1/%0d", name, done_cnt - d0, store_cnt - s0, exp_store);
    end
    checks++;
    if (req_cnt - r0 != req_exp) begin failures++; $display("FAIL %s req_cycles: got %0d required %0d", name, req_cnt - r0, req_exp); end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++; $display("FAIL %s txn_count: got %0d required %0d", name, act_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL %s txn%0d: got we=%0b addr=%h data=%h required we=%0b addr=%h data=%h", name, i,
                               act_q[i].we, act_q[i].addr, act_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
    act_q.delete();
    wait_q.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, store_value, mem_req, mem_we, error} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: busy/done/store/req/we/err=%b required 000000", {busy, done, store_value, mem_req, mem_we, error});
    end
    checks++;
    if ({source_data, dest_data, destination_write, mem_addr, mem_wdata} !== 80'b0) begin
      failures++; $display("FAIL reset_data: src=%h dst=%h dw=%h addr=%h wdata=%h required all 0", source_data, dest_data, destination_write, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reg_to_reg();
    run_op("reg_reg", 1'b0, 1'b0, 1'b0, 1'b1, 16'h1000, 16'h0234, 0, 0, 0, 1'b0);
    run_op("reg_nowrite", 1'b0, 1'b0, 1'b1, 1'b0, 16'h00aa, 16'h0055, 0, 0, 0, 1'b0);
  endtask

  task automatic test_mem_rmw();
    bus_mem[8'h10] = 16'h0005; ref_mem[8'h10] = 16'h0005;
    bus_mem[8'h20] = 16'h0003; ref_mem[8'h20] = 16'h0003;
    run_op("rmw_zero_wait", 1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h0020, 0, 0, 0, 1'b0);
    bus_mem[8'h20] = 16'h0003; ref_mem[8'h20] = 16'h0003;
    run_op("rmw_3_wait", 1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h0020, 3, 3, 3, 1'b0);
    run_op("same_addr", 1'b1, 1'b1, 1'b1, 1'b1, 16'h0030, 16'h0030, 1, 0, 2, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_op("busy_start", 1'b1, 1'b1, 1'b1, 1'b1, 16'h0041, 16'h0042, 2, 1, 0, 1'b1);
    run_op("busy_start_reg", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, 16'h0009, 0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_in_wr_dst();
    int d0, s0, n;
    resp_en = 1'b0;
    d0 = done_cnt; s0 = store_cnt;
    @(posedge clock); #1;
    source_addr = 16'h0123; dest_addr = 16'h0050; source_mem = 1'b0; dest_mem = 1'b1;
    dest_read = 1'b0; write_result = 1'b1; start = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #1;
      start = 1'b0;
      n++;
    end while (!(mem_req && mem_we) && n < 20);
    checks++;
    if (!(mem_req && mem_we)) begin failures++; $display("FAIL rst_wr reach_wr_dst: req=%0b we=%0b required 1/1", mem_req, mem_we); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, busy, done, store_value} !== 4'b0) begin
      failures++; $display("FAIL rst_wr async_clear: req/busy/done/store=%b required 0000", {mem_req, busy, done, store_value});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    resp_en = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (done_cnt != d0 || store_cnt != s0 || act_q.size() != 0 || bus_mem[8'h50] !== ref_mem[8'h50]) begin
      failures++; $display("FAIL rst_wr no_completion: done=%0d store=%0d txns=%0d required 0/0/0", done_cnt - d0, store_cnt - s0, act_q.size());
    end
    act_q.delete();
    wait_q.delete();
  endtask

  task automatic test_timeout();
    int d0, s0, reqs, n;
    resp_en = 1'b0;
    d0 = done_cnt; s0 = store_cnt;
    @(posedge clock); #1;
    source_addr = 16'h0060; dest_addr = 16'h0061; source_mem = 1'b1; dest_mem = 1'b1;
    dest_read = 1'b1; write_result = 1'b1; start = 1'b1;
    reqs = 0;
    n = 0;
`ifdef OAU_TIMEOUT_EN
    do begin
      @(posedge clock); #1;
      start = 1'b0;
      n++;
      if (mem_req) reqs++;
    end while (!done && n < 100);
    checks++;
    if (!done) begin failures++; $display("FAIL timeout done: no done within %0d cycles", n); end
    checks++;
    if (reqs != 15) begin failures++; $display("FAIL timeout req_cycles: got %0d required 15", reqs); end
    checks++;
    if (error !== 1'b1 || store_value !== 1'b0) begin failures++; $display("FAIL timeout flags: error=%0b store=%0b required 1/0", error, store_value); end
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (error !== 1'b1 || done_cnt - d0 != 1 || store_cnt != s0 || act_q.size() != 0) begin
      failures++; $display("FAIL timeout sticky: error=%0b done=%0d store=%0d txns=%0d required 1/1/0/0", error, done_cnt - d0, store_cnt - s0, act_q.size());
    end
`else
    do begin
      @(posedge clock); #1;
      start = 1'b0;
      n++;
      if (mem_req) reqs++;
    end while (n < 100);
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1 || reqs != 100) begin
      failures++; $display("FAIL no_timeout waiting: req=%0b busy=%0b req_cycles=%0d required 1/1/100", mem_req, busy, reqs);
    end
    checks++;
    if (error !== 1'b0 || done_cnt != d0) begin failures++; $display("FAIL no_timeout flags: error=%0b done=%0d required 0/0", error, done_cnt - d0); end
`endif
    do_reset();
    resp_en = 1'b1;
    checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL timeout reset_clear: error=%0b busy=%0b required 0/0", error, busy); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      bit sm, dm, dr, wr;
      logic [15:0] sa, da;
      sm = 1'($urandom); dm = 1'($urandom); dr = 1'($urandom); wr = 1'($urandom);
      sa = sm ? 16'($urandom_range(0, 255)) : 16'($urandom);
      da = dm ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if (k % 7 == 3) da = sa;
      run_op($sformatf("rand%0d", k), sm, dm, dr, wr, sa, da,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), k % 5 == 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 16'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    do_reset();
    test_reset();
    test_reg_to_reg();
    test_mem_rmw();
    test_start_while_busy();
    test_reset_in_wr_dst();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
